imm_encoder: RTL and testbench
==============================

// Module: imm_encoder
// PURPOSE
//  Inverse of the immediate generator: packs decoded instruction fields plus the
//  16-bit immediate value the datapath must see back into 16-bit instruction words.
//  Range-checks the value, encodes it and writes one word per command into instruction
//  memory at consecutive addresses. Used by the bench/boot path to load programs so
//  that ImmGen(mem word) == in_value always holds.
// PARAMETERS
//  WORD_SIZE  16       instruction/data width (matches `WORD_SIZE)
//  BASE_ADDR  16'h0000 first memory address written after reset/clear
//  MAX_WORDS  256      capacity; accepting command number MAX_WORDS+1 is an overflow
// PORTS
//  clk         in   1   single clock, rising edge
//  reset       in   1   asynchronous, active-high
//  clear       in   1   sync: return to IDLE, address=BASE_ADDR, word_count=0, err=0
//  in_valid    in   1   command valid
//  in_ready    out  1   command accepted when in_valid&in_ready at rising edge
//  in_opcode   in   4   ISA opcode (`*_OP)
//  in_rs/in_rt/in_rd in 2 each  register fields
//  in_func     in   6   R-type function field (opcode 15 only)
//  in_value    in   16  immediate value the decoder must reproduce
//  in_last     in   1   final command of program
//  mem_write   out  1   write request to instruction memory
//  mem_address out  16  write address
//  mem_data    out  16  encoded instruction word
//  mem_ack     in   1   memory accepted the write this cycle
//  done        out  1   sticky: last word written
//  err         out  1   sticky: command rejected
//  err_code    out  2   1=range, 2=unsupported opcode, 3=overflow; 0 when err=0
//  word_count  out  9   words written since reset/clear
// BEHAVIOUR
//  Reset: state IDLE; in_ready=1; mem_write=0; mem_address=BASE_ADDR; mem_data=0;
//   done=0; err=0; err_code=0; word_count=0. Reset mid-write abandons the word.
//  States: IDLE -> CHECK -> WRITE -> {IDLE|DONE}; CHECK -> ERROR. DONE/ERROR hold
//   until clear; clear overrides every state incl. WRITE (mem_write drops next cycle).
//  IDLE: in_ready=1 (only state with in_ready=1); on accept latch all inputs -> CHECK.
//  CHECK (1 cycle): build word {op,rs,rt,imm8} / {op,target12} / {op,rs,rt,rd,func}:
//   LHI,ORI: in_value[15:8]==0; imm8=in_value[7:0].
//   ADI,LWD,SWD: in_value[15:7] all equal (sign-extendable); imm8=in_value[7:0].
//   BNE,BEQ,BGZ,BLZ: t=in_value-1 (16-bit wrap); t[15:7] all equal; imm8=t[7:0];
//    legal in_value range -127..+128.
//   JMP,JAL: in_value[15:12]==0; word={op,in_value[11:0]}.
//   opcode 15 (R-type): in_value ignored.  opcodes 11..14: err_code=2.
//   range violation: err_code=1. word_count==MAX_WORDS at CHECK: err_code=3.
//   Error priority 3 > 2 > 1. Error -> ERROR, err=1, nothing written.
//  WRITE: mem_write=1, mem_address/mem_data stable until mem_ack. On mem_ack edge:
//   mem_write=0, mem_address+=1 (16-bit wrap), word_count+=1; latched last -> DONE
//   (done=1) else IDLE. mem_ack outside WRITE ignored.
//  Min latency accept->mem_write: 1 cycle (accept edge N, CHECK in N+1, WRITE from
//   N+2). Throughput with zero-wait ack: one word per 3 cycles.
//  in_value/fields may change after accept without effect.
// TESTING
//  ADI rs=1 rt=2 value=16'hFFFB -> mem_data=16'h46FB @BASE_ADDR, word_count=1.
//  BEQ value=128 -> imm8=8'h7F written; BEQ value=129 -> err=1, err_code=1, no write.
//  JAL value=16'h0123 -> 16'hA123; then opcode 12 -> err_code=2, ERROR until clear.
//  mem_ack held low 5 cycles -> mem_write/address/data stable; ack -> addr+1.
//  MAX_WORDS words then one more -> err_code=3; in_last on word 3 -> done=1, in_ready=0.
//  Round trip: random legal cmds -> ImmGen(mem_data)==in_value; reset during WRITE ->
//   all outputs at reset values next cycle.

Source files
------------

// File: rtl/imm_encoder.sv
`default_nettype none
// ============================================================================
//  Module   : imm_encoder
//  Purpose  : Inverse of the immediate generator. Packs decoded instruction
//             fields plus the immediate value the datapath must reproduce
//             into 16-bit instruction words. Each command is range-checked,
//             encoded and written to instruction memory at consecutive
//             addresses.
//  Ports    : clk, reset (async, active-high), clear (sync)
//             in_valid/in_ready handshake; in_opcode, in_rs, in_rt, in_rd,
//             in_func, in_value, in_last command fields
//             mem_write/mem_address/mem_data/mem_ack memory write port
//             done, err, err_code, word_count status
//  Revision : 1.0  initial release
// ============================================================================
module imm_encoder #(
    parameter int              WORD_SIZE = 16,
    parameter logic [15:0]     BASE_ADDR = 16'h0000,
    parameter int              MAX_WORDS = 256
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 clear,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [3:0]           in_opcode,
    input  logic [1:0]           in_rs,
    input  logic [1:0]           in_rt,
    input  logic [1:0]           in_rd,
    input  logic [5:0]           in_func,
    input  logic [WORD_SIZE-1:0] in_value,
    input  logic                 in_last,
    output logic                 mem_write,
    output logic [15:0]          mem_address,
    output logic [WORD_SIZE-1:0] mem_data,
    input  logic                 mem_ack,
    output logic                 done,
    output logic                 err,
    output logic [1:0]           err_code,
    output logic [8:0]           word_count
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_CHECK = 3'd1;
    localparam logic [2:0] S_WRITE = 3'd2;
    localparam logic [2:0] S_DONE  = 3'd3;
    localparam logic [2:0] S_ERROR = 3'd4;

    localparam logic [3:0] c_BNE_OP = 4'd0;
    localparam logic [3:0] c_BEQ_OP = 4'd1;
    localparam logic [3:0] c_BGZ_OP = 4'd2;
    localparam logic [3:0] c_BLZ_OP = 4'd3;
    localparam logic [3:0] c_ADI_OP = 4'd4;
    localparam logic [3:0] c_ORI_OP = 4'd5;
    localparam logic [3:0] c_LHI_OP = 4'd6;
    localparam logic [3:0] c_LWD_OP = 4'd7;
    localparam logic [3:0] c_SWD_OP = 4'd8;
    localparam logic [3:0] c_JMP_OP = 4'd9;
    localparam logic [3:0] c_JAL_OP = 4'd10;
    localparam logic [3:0] c_RTY_OP = 4'd15;

    localparam logic [8:0] c_MAX_WORDS = 9'(MAX_WORDS);

    logic [2:0]           r_state;
    logic [3:0]           r_op;
    logic [1:0]           r_rs;
    logic [1:0]           r_rt;
    logic [1:0]           r_rd;
    logic [5:0]           r_func;
    logic [WORD_SIZE-1:0] r_value;
    logic                 r_last;
    logic [15:0]          r_addr;
    logic [WORD_SIZE-1:0] r_data;
    logic [8:0]           r_count;
    logic [1:0]           r_err_code;

    logic [WORD_SIZE-1:0] w_word;
    logic [WORD_SIZE-1:0] w_br;
    logic                 w_range_ok;
    logic                 w_unsup;
    logic [1:0]           w_code;

    // Branch offsets are stored as (target distance - 1), so the encoder
    // subtracts one before the sign-extension check.
    assign w_br = r_value - WORD_SIZE'(1);

    always_comb begin
        w_word     = '0;
        w_range_ok = 1'b1;
        w_unsup    = 1'b0;
        case (r_op)
            c_BNE_OP, c_BEQ_OP, c_BGZ_OP, c_BLZ_OP: begin
                w_word     = {r_op, r_rs, r_rt, w_br[7:0]};
                w_range_ok = (&w_br[15:7]) | ~(|w_br[15:7]);
            end
            c_ADI_OP, c_LWD_OP, c_SWD_OP: begin
                w_word     = {r_op, r_rs, r_rt, r_value[7:0]};
                w_range_ok = (&r_value[15:7]) | ~(|r_value[15:7]);
            end
            c_ORI_OP, c_LHI_OP: begin
                w_word     = {r_op, r_rs, r_rt, r_value[7:0]};
                w_range_ok = ~(|r_value[15:8]);
            end
            c_JMP_OP, c_JAL_OP: begin
                w_word     = {r_op, r_value[11:0]};
                w_range_ok = ~(|r_value[15:12]);
            end
            c_RTY_OP: begin
                w_word     = {r_op, r_rs, r_rt, r_rd, r_func};
            end
            default: begin
                w_unsup    = 1'b1;
            end
        endcase
    end

    // Overflow outranks unsupported opcode, which outranks a range error.
    always_comb begin
        w_code = 2'd0;
        if (r_count == c_MAX_WORDS) begin
            w_code = 2'd3;
        end else if (w_unsup) begin
            w_code = 2'd2;
        end else if (!w_range_ok) begin
            w_code = 2'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_op       <= '0;
            r_rs       <= '0;
            r_rt       <= '0;
            r_rd       <= '0;
            r_func     <= '0;
            r_value    <= '0;
            r_last     <= 1'b0;
            r_addr     <= BASE_ADDR;
            r_data     <= '0;
            r_count    <= '0;
            r_err_code <= 2'd0;
        end else if (clear) begin
            r_state    <= S_IDLE;
            r_addr     <= BASE_ADDR;
            r_count    <= '0;
            r_err_code <= 2'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_op    <= in_opcode;
                        r_rs    <= in_rs;
                        r_rt    <= in_rt;
                        r_rd    <= in_rd;
                        r_func  <= in_func;
                        r_value <= in_value;
                        r_last  <= in_last;
                        r_state <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    if (w_code != 2'd0) begin
                        r_err_code <= w_code;
                        r_state    <= S_ERROR;
                    end else begin
                        r_data     <= w_word;
                        r_state    <= S_WRITE;
                    end
                end
                S_WRITE: begin
                    if (mem_ack) begin
                        r_addr  <= r_addr + 16'd1;
                        r_count <= r_count + 9'd1;
                        r_state <= r_last ? S_DONE : S_IDLE;
                    end
                end
                default: begin
                    // DONE and ERROR hold until clear.
                    r_state <= r_state;
                end
            endcase
        end
    end

    assign in_ready    = (r_state == S_IDLE);
    assign mem_write   = (r_state == S_WRITE);
    assign done        = (r_state == S_DONE);
    assign err         = (r_state == S_ERROR);
    assign err_code    = r_err_code;
    assign mem_address = r_addr;
    assign mem_data    = r_data;
    assign word_count  = r_count;

endmodule
`default_nettype wire

// File: tb/tb_imm_encoder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_imm_encoder
//  Purpose  : Self-checking bench for imm_encoder using a table of directed
//             commands with hand-computed words, plus sequences for stalls,
//             overflow, done, clear/reset during a write and round trips.
//  Revision : 1.0  initial release
// ============================================================================
module tb_imm_encoder;

    logic        clk = 1'b0;
    logic        reset;
    logic        clear;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_opcode;
    logic [1:0]  in_rs;
    logic [1:0]  in_rt;
    logic [1:0]  in_rd;
    logic [5:0]  in_func;
    logic [15:0] in_value;
    logic        in_last;
    logic        mem_write;
    logic [15:0] mem_address;
    logic [15:0] mem_data;
    logic        mem_ack;
    logic        done;
    logic        err;
    logic [1:0]  err_code;
    logic [8:0]  word_count;

    imm_encoder #(
        .WORD_SIZE (16),
        .BASE_ADDR (16'h0000),
        .MAX_WORDS (256)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .clear       (clear),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_opcode   (in_opcode),
        .in_rs       (in_rs),
        .in_rt       (in_rt),
        .in_rd       (in_rd),
        .in_func     (in_func),
        .in_value    (in_value),
        .in_last     (in_last),
        .mem_write   (mem_write),
        .mem_address (mem_address),
        .mem_data    (mem_data),
        .mem_ack     (mem_ack),
        .done        (done),
        .err         (err),
        .err_code    (err_code),
        .word_count  (word_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  op;
        logic [1:0]  rs;
        logic [1:0]  rt;
        logic [1:0]  rd;
        logic [5:0]  func;
        logic [15:0] value;
        logic [1:0]  code;
        logic [15:0] data;
    } vec_t;

    vec_t        vecs[15];
    int          errors = 0;
    int          checks = 0;
    logic [15:0] exp_addr = 16'h0000;
    logic [8:0]  exp_cnt  = 9'd0;

    function automatic vec_t mk(logic [3:0] op, logic [1:0] rs, logic [1:0] rt,
                                logic [1:0] rd, logic [5:0] func, logic [15:0] value,
                                logic [1:0] code, logic [15:0] data);
        vec_t v;
        v.op = op; v.rs = rs; v.rt = rt; v.rd = rd; v.func = func;
        v.value = value; v.code = code; v.data = data;
        return v;
    endfunction

    // Reference decoder: what the immediate generator recovers from a word.
    function automatic logic [15:0] immgen(logic [15:0] w);
        logic [15:0] sx;
        sx = {{8{w[7]}}, w[7:0]};
        case (w[15:12])
            4'd0, 4'd1, 4'd2, 4'd3: immgen = sx + 16'd1;
            4'd4, 4'd7, 4'd8:       immgen = sx;
            4'd5, 4'd6:             immgen = {8'h00, w[7:0]};
            default:                immgen = {4'h0, w[11:0]};
        endcase
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        exp_addr = 16'h0000;
        exp_cnt  = 9'd0;
    endtask

    // Handshake one command; returns two cycles later (state after CHECK).
    task automatic issue(input logic [3:0] op, input logic [1:0] rs, input logic [1:0] rt,
                         input logic [1:0] rd, input logic [5:0] func, input logic [15:0] value,
                         input logic last);
        int n;
        n = 0;
        while (!in_ready && n < 20) begin
            tick();
            n++;
        end
        if (!in_ready) begin
            errors++;
            checks++;
            $display("FAIL issue_timeout: in_ready=%0b expected 1", in_ready);
        end
        in_valid  = 1'b1;
        in_opcode = op; in_rs = rs; in_rt = rt; in_rd = rd;
        in_func   = func; in_value = value; in_last = last;
        tick();
        in_valid  = 1'b0;
        // Fields changing after accept must have no effect.
        in_opcode = 4'(($urandom)); in_value = 16'($urandom);
        in_rs = 2'($urandom); in_rt = 2'($urandom); in_func = 6'($urandom);
        in_last = 1'b0;
        tick();
    endtask

    task automatic finish_write(input string nm, input logic [15:0] data);
        chk({nm, "_wr"},   mem_write,   1);
        chk({nm, "_addr"}, mem_address, exp_addr);
        chk({nm, "_data"}, mem_data,    data);
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        exp_addr = exp_addr + 16'd1;
        exp_cnt  = exp_cnt + 9'd1;
        chk({nm, "_wrdrop"}, mem_write,  0);
        chk({nm, "_cnt"},    word_count, exp_cnt);
    endtask

    initial begin
        logic [3:0]  rop;
        logic [15:0] rval;
        int          sel;

        reset = 1'b1; clear = 1'b0; in_valid = 1'b0; mem_ack = 1'b0;
        in_opcode = '0; in_rs = '0; in_rt = '0; in_rd = '0;
        in_func = '0; in_value = '0; in_last = 1'b0;

        vecs[0]  = mk(4'd4,  2'd1, 2'd2, 2'd0, 6'h00, 16'hFFFB, 2'd0, 16'h46FB);
        vecs[1]  = mk(4'd1,  2'd0, 2'd0, 2'd0, 6'h00, 16'd128,  2'd0, 16'h107F);
        vecs[2]  = mk(4'd1,  2'd0, 2'd0, 2'd0, 6'h00, 16'd129,  2'd1, 16'h0000);
        vecs[3]  = mk(4'd10, 2'd0, 2'd0, 2'd0, 6'h00, 16'h0123, 2'd0, 16'hA123);
        vecs[4]  = mk(4'd12, 2'd0, 2'd0, 2'd0, 6'h00, 16'h0000, 2'd2, 16'h0000);
        vecs[5]  = mk(4'd6,  2'd3, 2'd0, 2'd0, 6'h00, 16'h00AB, 2'd0, 16'h6CAB);
        vecs[6]  = mk(4'd5,  2'd0, 2'd0, 2'd0, 6'h00, 16'h0100, 2'd1, 16'h0000);
        vecs[7]  = mk(4'd0,  2'd2, 2'd1, 2'd0, 6'h00, 16'hFF81, 2'd0, 16'h0980);
        vecs[8]  = mk(4'd3,  2'd0, 2'd0, 2'd0, 6'h00, 16'hFF80, 2'd1, 16'h0000);
        vecs[9]  = mk(4'd15, 2'd1, 2'd2, 2'd3, 6'h2A, 16'hFFFF, 2'd0, 16'hF6EA);
        vecs[10] = mk(4'd9,  2'd0, 2'd0, 2'd0, 6'h00, 16'h1000, 2'd1, 16'h0000);
        vecs[11] = mk(4'd8,  2'd0, 2'd3, 2'd0, 6'h00, 16'h007F, 2'd0, 16'h837F);
        vecs[12] = mk(4'd7,  2'd0, 2'd0, 2'd0, 6'h00, 16'h0080, 2'd1, 16'h0000);
        vecs[13] = mk(4'd11, 2'd0, 2'd0, 2'd0, 6'h00, 16'hFFFF, 2'd2, 16'h0000);
        vecs[14] = mk(4'd2,  2'd0, 2'd1, 2'd0, 6'h00, 16'h0001, 2'd0, 16'h2100);

        // Reset state
        #12;
        chk("rst_ready", in_ready,    1);
        chk("rst_wr",    mem_write,   0);
        chk("rst_addr",  mem_address, 16'h0000);
        chk("rst_data",  mem_data,    16'h0000);
        chk("rst_done",  done,        0);
        chk("rst_err",   err,         0);
        chk("rst_code",  err_code,    0);
        chk("rst_cnt",   word_count,  0);
        reset = 1'b0;
        tick();

        // Table of directed commands
        for (int i = 0; i < 15; i++) begin
            issue(vecs[i].op, vecs[i].rs, vecs[i].rt, vecs[i].rd, vecs[i].func,
                  vecs[i].value, 1'b0);
            if (vecs[i].code != 2'd0) begin
                chk($sformatf("v%0d_err", i),  err,       1);
                chk($sformatf("v%0d_code", i), err_code,  vecs[i].code);
                chk($sformatf("v%0d_nowr", i), mem_write, 0);
                tick();
                chk($sformatf("v%0d_hold", i), {err, in_ready}, 2'b10);
                do_clear();
                chk($sformatf("v%0d_clr", i), {err, err_code, in_ready, mem_address},
                    {1'b0, 2'd0, 1'b1, 16'h0000});
            end else begin
                finish_write($sformatf("v%0d", i), vecs[i].data);
            end
        end

        // Ack stall: outputs stable while ack is low
        do_clear();
        issue(4'd4, 2'd0, 2'd1, 2'd0, 6'h00, 16'h0005, 1'b0);
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("stall%0d", k), {mem_write, mem_address, mem_data},
                {1'b1, 16'h0000, 16'h4105});
            tick();
        end
        finish_write("stall_end", 16'h4105);
        chk("stall_addr", mem_address, 16'h0001);

        // Clear during WRITE drops the write next cycle
        issue(4'd4, 2'd0, 2'd0, 2'd0, 6'h00, 16'h0001, 1'b0);
        chk("cw_wr", mem_write, 1);
        do_clear();
        chk("cw_state", {mem_write, in_ready, mem_address, word_count},
            {1'b0, 1'b1, 16'h0000, 9'd0});

        // Overflow: MAX_WORDS words, then one more (unsupported opcode too)
        for (int k = 0; k < 256; k++) begin
            issue(4'd4, 2'd0, 2'd0, 2'd0, 6'h00, 16'(k & 8'h3F), 1'b0);
            mem_ack = 1'b1;
            tick();
            mem_ack = 1'b0;
        end
        chk("ovf_cnt",  word_count,  9'd256);
        chk("ovf_addr", mem_address, 16'h0100);
        issue(4'd12, 2'd0, 2'd0, 2'd0, 6'h00, 16'h0000, 1'b0);
        chk("ovf_err",  {err, err_code, mem_write}, {1'b1, 2'd3, 1'b0});
        do_clear();

        // Done after in_last on the third word
        for (int k = 0; k < 3; k++) begin
            issue(4'd5, 2'd1, 2'd1, 2'd0, 6'h00, 16'(k), (k == 2));
            finish_write($sformatf("dn%0d", k), 16'h5500 | 16'(k));
        end
        chk("dn_done",  {done, in_ready, err}, {1'b1, 1'b0, 1'b0});
        in_valid = 1'b1;
        tick();
        tick();
        in_valid = 1'b0;
        chk("dn_hold",  {done, mem_write, word_count}, {1'b1, 1'b0, 9'd3});
        do_clear();
        chk("dn_clr",   {done, in_ready}, 2'b01);

        // Round trip with random legal commands
        for (int k = 0; k < 20; k++) begin
            sel = $urandom_range(0, 4);
            case (sel)
                0: begin rop = 4'($urandom_range(0, 3));
                         rval = 16'($urandom_range(0, 255)) - 16'd127; end
                1: begin rop = 4'd4; rval = 16'($urandom_range(0, 255)) - 16'd128; end
                2: begin rop = 4'd6; rval = 16'($urandom_range(0, 255)); end
                3: begin rop = 4'd10; rval = 16'($urandom_range(0, 4095)); end
                default: begin rop = 4'd8; rval = 16'($urandom_range(0, 255)) - 16'd128; end
            endcase
            issue(rop, 2'd2, 2'd3, 2'd0, 6'h00, rval, 1'b0);
            chk($sformatf("rt%0d_wr", k),  mem_write, 1);
            chk($sformatf("rt%0d_imm", k), {mem_data[15:12], immgen(mem_data)}, {rop, rval});
            mem_ack = 1'b1;
            tick();
            mem_ack = 1'b0;
        end

        // Reset during WRITE abandons the word
        issue(4'd4, 2'd1, 2'd1, 2'd0, 6'h00, 16'h0011, 1'b0);
        chk("rw_wr", mem_write, 1);
        #1 reset = 1'b1;
        #1;
        chk("rw_rst", {in_ready, mem_write, mem_address, mem_data, done, err, err_code, word_count},
            {1'b1, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 2'd0, 9'd0});
        reset = 1'b0;
        tick();
        chk("rw_after", {in_ready, mem_write}, 2'b10);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
